axi4lite_sram: RTL
==================

AXI4LITE_SRAM -- requirements
Module: axi4lite_sram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32: address bus width.
REQ-003 SHALL have parameter MEM_WORDS, default 1024: number of 32-bit storage words.
REQ-004 SHALL have parameter RD_LAT, default 1: cycles from AR handshake to first rvalid, legal range 1..15.
REQ-005 SHALL have parameter WR_LAT, default 1: cycles from the capture of both AW and W to first bvalid, legal range 1..15.
REQ-006 SHALL provide the following ports, clock and reset first:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- arvalid  in  1 / araddr  in  ADDR_WIDTH / arready  out  1  read-address channel.
- rvalid  out  1 / rdata  out  DATA_WIDTH / rresp  out  2 / rready  in  1  read-data channel.
- awvalid  in  1 / awaddr  in  ADDR_WIDTH / awready  out  1  write-address channel.
- wvalid  in  1 / wdata  in  DATA_WIDTH / wstrb  in  4 / wready  out  1  write-data channel.
- bvalid  out  1 / bresp  out  2 / bready  in  1  write-response channel.

Function
REQ-007 SHALL act as the AXI4-Lite slave consumed directly by the arbiter's SRAM-side port: word memory of MEM_WORDS entries, word index = addr[log2(MEM_WORDS)+1:2], and addr[1:0] ignored.
REQ-008 SHALL implement the read FSM R_IDLE -> R_WAIT -> R_RESP -> R_IDLE.
- arready=1 only in R_IDLE.
- AR handshake latches the address and loads the latency counter.
- rvalid=1 exactly RD_LAT cycles after the AR handshake cycle.
REQ-009 SHALL sample memory into a held rdata register on entry to R_RESP, and keep rdata/rresp stable while rvalid=1 and rready=0.
REQ-010 SHALL return to R_IDLE on rvalid&rready, with arready=1 in the following cycle; AR and R handshakes SHALL NOT complete in the same cycle.
REQ-011 SHALL treat a read whose araddr[ADDR_WIDTH-1:2] >= MEM_WORDS as out of range: rresp=2'b10 (SLVERR), rdata=0, same latency; in-range reads SHALL give rresp=2'b00.
REQ-012 SHALL implement the write FSM W_IDLE -> W_WAIT -> W_RESP -> W_IDLE.
- In W_IDLE, AW and W are captured independently, in either order or in the same cycle.
- awready=1 until AW is captured; wready=1 until W is captured.
REQ-013 SHALL enter W_WAIT in the cycle after both AW and W are held, and assert bvalid exactly WR_LAT cycles after that entry.
REQ-014 SHALL commit the write on entry to W_RESP, updating byte i only where wstrb[i]=1; wstrb=0 SHALL leave memory unchanged and still respond OKAY.
REQ-015 SHALL give bresp=2'b10 and leave memory unchanged for an out-of-range write; otherwise bresp=2'b00.
REQ-016 SHALL hold bvalid until bready, then return to W_IDLE with awready=wready=1 in the next cycle.
REQ-017 SHALL run the read and write channels fully concurrently; when a read sample and a write commit hit the same word in the same cycle, the read SHALL return the pre-write data.

Reset
REQ-018 SHALL, while rst=0, force both FSMs idle and all counters to 0, with outputs: arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
REQ-019 SHALL set arready=awready=wready=1 in the first cycle after rst deasserts.
REQ-020 SHALL abandon any in-flight transaction when reset asserts mid-operation, with no memory write.
REQ-021 SHALL leave memory contents unchanged by reset.

Configuration
REQ-022 SHALL, with macro SRAM_RAND_DELAY_EN defined, replace RD_LAT and WR_LAT with a per-transaction latency of lfsr[2:0]+1 (range 1..8).
- lfsr is an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, reset to 8'hA5, advancing every cycle.
- Sampled at the AR handshake for reads and on W_WAIT entry for writes.
REQ-023 SHALL, without SRAM_RAND_DELAY_EN, use the fixed RD_LAT and WR_LAT only, with no LFSR logic present.

Verification
REQ-024 SHALL cover: RD_LAT=1, write 0xDEADBEEF to 0x10 with wstrb=4'hF, then read 0x10 -> rvalid 1 cycle after the AR handshake, rdata=0xDEADBEEF, rresp=0.
REQ-025 SHALL cover: word 0x10 holds 0xDEADBEEF, write 0x000000AA with wstrb=4'b0001 -> read 0x10 returns 0xDEADBEAA.
REQ-026 SHALL cover: W presented 3 cycles before AW -> wready drops after the W capture, bvalid asserts WR_LAT cycles after W_WAIT entry, single commit.
REQ-027 SHALL cover: read at address MEM_WORDS*4 -> rresp=2'b10, rdata=0; write at the same address -> bresp=2'b10 and memory unchanged.
REQ-028 SHALL cover: rready held 0 for 5 cycles with rvalid=1 -> rdata stable and arready=0 throughout; arready=1 the cycle after rready=1.
REQ-029 SHALL cover: rst asserted during R_WAIT -> rvalid=0, arready=0 immediately; arready=1 the first cycle after release.

Source files
------------

// File: rtl/axi4lite_sram.sv
// AXI4-Lite slave in front of a byte-writable word memory, with independent read and write FSMs.
// Define SRAM_RAND_DELAY_EN to replace RD_LAT/WR_LAT with a per-transaction LFSR-derived latency (1..8).
module axi4lite_sram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int RD_LAT     = 1,
  parameter int WR_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arvalid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  output logic                  arready,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  input  logic                  rready,
  input  logic                  awvalid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  awready,
  input  logic                  wvalid,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  output logic                  wready,
  output logic                  bvalid,
  output logic [1:0]            bresp,
  input  logic                  bready
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH-3:0] WORDS_LIMIT = (ADDR_WIDTH-2)'(MEM_WORDS);

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Ready outputs stay low until the first clock edge after reset release.
  logic out_en;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) out_en <= 1'b0;
    else      out_en <= 1'b1;
  end

  logic [3:0] rd_lat;
  logic [3:0] wr_lat;

`ifdef SRAM_RAND_DELAY_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 8'hA5;
    else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign rd_lat = {1'b0, lfsr[2:0]} + 4'd1;
  assign wr_lat = {1'b0, lfsr[2:0]} + 4'd1;
`else
  assign rd_lat = 4'(RD_LAT);
  assign wr_lat = 4'(WR_LAT);
`endif

  // ---------------- read channel ----------------
  r_state_t              r_state, r_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_cnt;
  logic                  ar_hs;
  logic [ADDR_WIDTH-1:0] rd_src;
  logic                  rd_oor;
  logic [IDX_W-1:0]      rd_idx;

  assign ar_hs  = arvalid && arready;
  // A latency-1 read samples memory at the handshake edge itself, so the address comes straight from araddr.
  assign rd_src = (r_state == R_IDLE) ? araddr : r_addr;
  assign rd_oor = rd_src[ADDR_WIDTH-1:2] >= WORDS_LIMIT;
  assign rd_idx = rd_src[IDX_W+1:2];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= R_IDLE;
    else      r_state <= r_next;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_next = (rd_lat <= 4'd1) ? R_RESP : R_WAIT;
      R_WAIT:  if (r_cnt == 4'd0) r_next = R_RESP;
      R_RESP:  if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = out_en && (r_state == R_IDLE);
    rvalid  = (r_state == R_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr <= '0;
      r_cnt  <= 4'd0;
      rdata  <= '0;
      rresp  <= 2'b00;
    end else begin
      if (ar_hs) begin
        r_addr <= araddr;
        r_cnt  <= (rd_lat >= 4'd2) ? rd_lat - 4'd2 : 4'd0;
      end else if (r_state == R_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state != R_RESP && r_next == R_RESP) begin
        rdata <= rd_oor ? '0 : mem[rd_idx];
        rresp <= rd_oor ? 2'b10 : 2'b00;
      end
    end
  end

  // ---------------- write channel ----------------
  w_state_t              w_state, w_next;
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [3:0]            w_strb;
  logic [3:0]            w_cnt;
  logic                  aw_hs, w_hs, commit;
  logic                  w_oor;
  logic [IDX_W-1:0]      w_idx;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign w_oor  = w_addr[ADDR_WIDTH-1:2] >= WORDS_LIMIT;
  assign w_idx  = w_addr[IDX_W+1:2];
  assign commit = (w_state == W_WAIT) && (w_next == W_RESP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) w_state <= W_IDLE;
    else      w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if ((aw_held || aw_hs) && (w_held || w_hs)) w_next = W_WAIT;
      W_WAIT:  if (w_cnt == 4'd0) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = out_en && (w_state == W_IDLE) && !aw_held;
    wready  = out_en && (w_state == W_IDLE) && !w_held;
    bvalid  = (w_state == W_RESP);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      w_addr  <= '0;
      w_data  <= '0;
      w_strb  <= 4'd0;
      w_cnt   <= 4'd0;
      bresp   <= 2'b00;
    end else begin
      if (aw_hs) begin
        w_addr  <= awaddr;
        aw_held <= 1'b1;
      end
      if (w_hs) begin
        w_data <= wdata;
        w_strb <= wstrb;
        w_held <= 1'b1;
      end
      if (w_state == W_IDLE && w_next == W_WAIT) begin
        w_cnt <= (wr_lat != 4'd0) ? wr_lat - 4'd1 : 4'd0;
      end else if (w_state == W_WAIT && w_cnt != 4'd0) begin
        w_cnt <= w_cnt - 4'd1;
      end
      if (commit) bresp <= w_oor ? 2'b10 : 2'b00;
      if (w_state == W_RESP && bready) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // NOTE: the storage array has no reset; its contents survive rst, and commit is already gated by the reset FSM state.
  always_ff @(posedge clk) begin
    if (commit && !w_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb[i]) mem[w_idx][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_src[1:0], w_addr[1:0]};

endmodule
